// File: rtl/issue_ctrl_pkg.sv
// issue_ctrl_pkg: queue sizing and opcode classification shared by the issue controller.
package issue_ctrl_pkg;
    localparam int IQ_LOG = 4;
    localparam int IQ_DEPTH = 1 << IQ_LOG;
    localparam int IQ_SLACK = 1;
    localparam logic [6:0] OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    function automatic logic is_mem(input logic [31:0] inst);
        return inst[6:0] == OPC_LOAD || inst[6:0] == OPC_STORE;
    endfunction
endpackage

// File: rtl/issue_ctrl_fifo.sv
// issue_ctrl_fifo: circular-queue pointers, occupancy and early-full flag.
module issue_ctrl_fifo
    import issue_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    output logic [IQ_LOG-1:0] head,
    output logic [IQ_LOG-1:0] tail,
    output logic [IQ_LOG:0]   count,
    output logic              full
);
    localparam logic [IQ_LOG:0] FULL_AT = (IQ_LOG+1)'(IQ_DEPTH - IQ_SLACK);
    logic [IQ_LOG:0] count_next;

    assign count_next = clear ? '0 : count + (IQ_LOG+1)'(push) - (IQ_LOG+1)'(pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            full  <= 1'b0;
        end else if (en) begin
            head  <= clear ? '0 : head + IQ_LOG'(pop);
            tail  <= clear ? '0 : tail + IQ_LOG'(push);
            count <= count_next;
            full  <= count_next >= FULL_AT;
        end
    end
endmodule

// File: rtl/issue_ctrl.sv
// issue_ctrl: instruction queue between fetch and issue, gated by ROB/RS/LSB capacity.
module issue_ctrl
    import issue_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear,
    input  logic        if_valid,
    input  logic [31:0] if_inst,
    input  logic [31:0] if_pc,
    output logic        iq_full,
    input  logic        rob_full,
    input  logic        rs_full,
    input  logic        lsb_full,
    output logic        issue_valid,
    output logic [31:0] issue_inst,
    output logic [31:0] issue_pc,
    output logic [31:0] issue_cnt,
    output logic [31:0] stall_cnt,
    output logic        overflow
);
    localparam logic [IQ_LOG:0] CNT_MAX = (IQ_LOG+1)'(IQ_DEPTH);
    logic [31:0] inst_mem [IQ_DEPTH];
    logic [31:0] pc_mem [IQ_DEPTH];
    logic [IQ_LOG-1:0] head, tail;
    logic [IQ_LOG:0] count;
    logic nonempty, take, push, pop;

    assign nonempty = count != '0;
    assign take = rdy & ~clear;
    assign issue_inst = nonempty ? inst_mem[head] : '0;
    assign issue_pc = nonempty ? pc_mem[head] : '0;
    assign issue_valid = take & nonempty & ~rob_full & (is_mem(issue_inst) ? ~lsb_full : ~rs_full);
    assign pop = issue_valid;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push = take & if_valid & (count != CNT_MAX | pop);

    issue_ctrl_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .en    (rdy),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .head  (head),
        .tail  (tail),
        .count (count),
        .full  (iq_full)
    );

    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[tail] <= if_inst;
            pc_mem[tail]   <= if_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt <= '0;
            stall_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            if (pop) issue_cnt <= issue_cnt + 32'd1;
            if (take & nonempty & ~issue_valid) stall_cnt <= stall_cnt + 32'd1;
            if (take & if_valid & count == CNT_MAX & ~pop) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: directed vectors for issue_ctrl with a small FIFO scoreboard for the random phase.
module tb_issue_ctrl;
    logic clk = 0, rst = 1, rdy = 1, clear = 0, if_valid = 0;
    logic [31:0] if_inst = 0, if_pc = 0;
    logic rob_full = 0, rs_full = 0, lsb_full = 0;
    logic iq_full, issue_valid, overflow;
    logic [31:0] issue_inst, issue_pc, issue_cnt, stall_cnt;
    int vectors = 0, errors = 0;
    logic [31:0] s0, i0, pcn;
    logic [31:0] q[$];
    logic iv, rf, exp_v;

    localparam logic [31:0] ADDI = 32'h00000013, ADD = 32'h00000033;
    localparam logic [31:0] LW = 32'h00002003, SW = 32'h00002023;

    issue_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .if_valid(if_valid),
        .if_inst(if_inst), .if_pc(if_pc), .iq_full(iq_full), .rob_full(rob_full),
        .rs_full(rs_full), .lsb_full(lsb_full), .issue_valid(issue_valid),
        .issue_inst(issue_inst), .issue_pc(issue_pc), .issue_cnt(issue_cnt),
        .stall_cnt(stall_cnt), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        check("rst_valid", 32'(issue_valid), 0);
        check("rst_cnt", issue_cnt, 0);
        check("rst_full", 32'(iq_full), 0);
        rst = 0;
        step();
        // pass-through of three instructions
        if_inst = ADDI; if_valid = 1; if_pc = 32'h0;
        #1 check("pt_empty", 32'(issue_valid), 0);
        step();
        if_pc = 32'h4;
        #1 check("pt_v0", 32'(issue_valid), 1);
        check("pt_pc0", issue_pc, 32'h0);
        step();
        if_pc = 32'h8;
        #1 check("pt_pc4", issue_pc, 32'h4);
        step();
        if_valid = 0;
        #1 check("pt_pc8", issue_pc, 32'h8);
        step();
        check("pt_done", 32'(issue_valid), 0);
        check("pt_icnt", issue_cnt, 3);
        check("pt_pc_empty", issue_pc, 0);
        // back-pressure and overflow
        rob_full = 1; if_valid = 1;
        for (int i = 0; i < 16; i++) begin
            if_pc = 32'h400 + 32'(4 * i);
            step();
            check("bp_full", 32'(iq_full), 32'(i >= 14));
        end
        check("bp_noovf", 32'(overflow), 0);
        if_pc = 32'h500;
        step();
        check("bp_ovf", 32'(overflow), 1);
        check("bp_count", 32'(dut.count), 16);
        check("bp_blocked", 32'(issue_valid), 0);
        rob_full = 0; if_pc = 32'h600;
        #1 check("pp_head", issue_pc, 32'h400);
        step();
        check("pp_count", 32'(dut.count), 16);
        check("pp_ovf_sticky", 32'(overflow), 1);
        if_valid = 0;
        for (int i = 0; i < 16; i++) begin
            #1 check("drain_v", 32'(issue_valid), 1);
            check("drain_pc", issue_pc, i < 15 ? 32'h404 + 32'(4 * i) : 32'h600);
            step();
        end
        check("drain_empty", 32'(issue_valid), 0);
        check("drain_nofull", 32'(iq_full), 0);
        // routing stalls
        lsb_full = 1; if_valid = 1; if_inst = LW; if_pc = 32'h200;
        step();
        if_valid = 0;
        #1 check("rt_lw_lsb", 32'(issue_valid), 0);
        s0 = stall_cnt;
        step();
        check("rt_stall", stall_cnt, s0 + 1);
        lsb_full = 0; rs_full = 1;
        #1 check("rt_lw_rs", 32'(issue_valid), 1);
        step();
        lsb_full = 1; rs_full = 0; if_valid = 1; if_inst = SW; if_pc = 32'h208;
        step();
        if_valid = 0;
        #1 check("rt_sw_lsb", 32'(issue_valid), 0);
        lsb_full = 0;
        #1 check("rt_sw_go", 32'(issue_valid), 1);
        step();
        rs_full = 1; if_valid = 1; if_inst = ADD; if_pc = 32'h204;
        step();
        if_valid = 0;
        #1 check("rt_add_rs", 32'(issue_valid), 0);
        rs_full = 0; rob_full = 1;
        #1 check("rt_add_rob", 32'(issue_valid), 0);
        rob_full = 0;
        #1 check("rt_add_go", 32'(issue_valid), 1);
        check("rt_add_pc", issue_pc, 32'h204);
        step();
        check("rt_empty", 32'(issue_valid), 0);
        // random push/pop against a scoreboard
        if_inst = ADDI; pcn = 32'h1000;
        for (int c = 0; c < 40; c++) begin
            iv = $urandom_range(0, 3) != 0;
            rf = $urandom_range(0, 2) == 0;
            if_valid = iv; rob_full = rf; if_pc = pcn;
            #1 exp_v = q.size() != 0 && !rf;
            check("rnd_v", 32'(issue_valid), 32'(exp_v));
            if (exp_v) check("rnd_pc", issue_pc, q[0]);
            step();
            if (exp_v) void'(q.pop_front());
            if (iv && (q.size() < 16 || exp_v)) begin
                q.push_back(pcn);
                pcn += 4;
            end
            check("rnd_full", 32'(iq_full), 32'(q.size() >= 15));
        end
        // flush
        if_valid = 0; rob_full = 0; clear = 1;
        step();
        clear = 0; rob_full = 1; if_valid = 1;
        for (int i = 0; i < 5; i++) begin
            if_pc = 32'h300 + 32'(4 * i);
            step();
        end
        rob_full = 0; clear = 1; if_pc = 32'h3f0;
        #1 check("fl_novalid", 32'(issue_valid), 0);
        i0 = issue_cnt;
        step();
        clear = 0; if_valid = 0;
        #1 check("fl_empty", 32'(issue_valid), 0);
        check("fl_count", 32'(dut.count), 0);
        check("fl_full", 32'(iq_full), 0);
        check("fl_icnt", issue_cnt, i0);
        check("fl_pc", issue_pc, 0);
        // rdy freeze
        rob_full = 1; if_valid = 1;
        for (int i = 0; i < 3; i++) begin
            if_pc = 32'h700 + 32'(4 * i);
            step();
        end
        rdy = 0; rob_full = 0; if_pc = 32'h7f0;
        s0 = stall_cnt; i0 = issue_cnt;
        for (int i = 0; i < 3; i++) begin
            #1 check("frz_valid", 32'(issue_valid), 0);
            step();
        end
        check("frz_stall", stall_cnt, s0);
        check("frz_icnt", issue_cnt, i0);
        check("frz_count", 32'(dut.count), 3);
        rdy = 1; if_valid = 0;
        #1 check("frz_resume", 32'(issue_valid), 1);
        check("frz_pc", issue_pc, 32'h700);
        // async reset mid-run
        #2 rst = 1;
        #1 check("arst_valid", 32'(issue_valid), 0);
        check("arst_icnt", issue_cnt, 0);
        check("arst_stall", stall_cnt, 0);
        check("arst_ovf", 32'(overflow), 0);
        check("arst_pc", issue_pc, 0);
        step();
        rst = 0;
        step();
        check("arst_hold", 32'(issue_valid), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
